mips_single_cycle_top: RTL and testbench

- Single-cycle 32-bit MIPS processor core with on-chip instruction ROM and data RAM.
- Every instruction fetches, decodes, executes and writes back within one clock period.
- All datapath and control signals are exported as debug outputs for bench observation.
- Top-level block of the CPU subsystem; no external bus.

---
 rtl/mips_single_cycle_top.sv | 189 ++++++++++++++++++
 tb/tb_mips_single_cycle_top.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mips_single_cycle_top.sv
`default_nettype none
// ============================================================================
// Module      : mips_single_cycle_top
// Description : Single-cycle 32-bit MIPS core with an on-chip instruction ROM
//               and data RAM. Every datapath and control signal is exported
//               so that it can be observed directly.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_single_cycle_top #(
  parameter int    IMEM_DEPTH = 64,
  parameter int    DMEM_DEPTH = 64,
  parameter string IMEM_FILE  = "program.hex"
) (
  input  logic        CLK,
  input  logic        reset,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic [31:0] ALUresult,
  output logic [31:0] WriteDataMem,
  output logic [31:0] ReadDataMem,
  output logic [31:0] WD3,
  output logic [31:0] pcjump,
  output logic [3:0]  ALUControl,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        BEQ,
  output logic        BNE,
  output logic        jump,
  output logic        JR,
  output logic        JAL,
  output logic        zero
);

  localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] dmem [DMEM_DEPTH];
  logic [31:0] rf   [32];

  // Instruction fields
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;

  logic [29:0] imem_idx_full;
  logic [29:0] dmem_idx_full;
  logic [4:0]  wa3;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] srcb;
  logic [31:0] imm_sext;
  logic [31:0] imm_zext;
  logic [31:0] pc_plus4;
  logic [31:0] pc_branch;
  logic [31:0] pc_next;
  logic        zero_ext;
  logic        branch_taken;
  logic        unused_idx;

  assign imem_idx_full = pc[31:2] % 30'(IMEM_DEPTH);
  assign inst          = imem[imem_idx_full[IAW-1:0]];

  assign op    = inst[31:26];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign rd    = inst[15:11];
  assign funct = inst[5:0];
  assign imm   = inst[15:0];

  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'h0000, imm};

  // Main and ALU decoder; anything unrecognised falls through to a NOP
  always_comb begin
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    RegDst     = 1'b0;
    ALUSrc     = 1'b0;
    MemtoReg   = 1'b0;
    BEQ        = 1'b0;
    BNE        = 1'b0;
    jump       = 1'b0;
    JR         = 1'b0;
    JAL        = 1'b0;
    ALUControl = ALU_ADD;
    zero_ext   = 1'b0;
    case (op)
      6'h00: begin
        case (funct)
          6'h20: begin RegDst = 1'b1; RegWrite = 1'b1; ALUControl = ALU_ADD; end
          6'h22: begin RegDst = 1'b1; RegWrite = 1'b1; ALUControl = ALU_SUB; end
          6'h24: begin RegDst = 1'b1; RegWrite = 1'b1; ALUControl = ALU_AND; end
          6'h25: begin RegDst = 1'b1; RegWrite = 1'b1; ALUControl = ALU_OR;  end
          6'h27: begin RegDst = 1'b1; RegWrite = 1'b1; ALUControl = ALU_NOR; end
          6'h2A: begin RegDst = 1'b1; RegWrite = 1'b1; ALUControl = ALU_SLT; end
          6'h08: begin RegDst = 1'b1; JR = 1'b1; end
          default: ;
        endcase
      end
      6'h08: begin ALUSrc = 1'b1; RegWrite = 1'b1; ALUControl = ALU_ADD; end
      6'h0A: begin ALUSrc = 1'b1; RegWrite = 1'b1; ALUControl = ALU_SLT; end
      6'h0C: begin ALUSrc = 1'b1; RegWrite = 1'b1; ALUControl = ALU_AND; zero_ext = 1'b1; end
      6'h0D: begin ALUSrc = 1'b1; RegWrite = 1'b1; ALUControl = ALU_OR;  zero_ext = 1'b1; end
      6'h23: begin ALUSrc = 1'b1; MemtoReg = 1'b1; RegWrite = 1'b1; ALUControl = ALU_ADD; end
      6'h2B: begin ALUSrc = 1'b1; MemWrite = 1'b1; ALUControl = ALU_ADD; end
      6'h04: begin BEQ = 1'b1; ALUControl = ALU_SUB; end
      6'h05: begin BNE = 1'b1; ALUControl = ALU_SUB; end
      6'h02: begin jump = 1'b1; end
      6'h03: begin jump = 1'b1; JAL = 1'b1; RegWrite = 1'b1; end
      default: ;
    endcase
  end

  // Register file read ports; $0 is hardwired to zero
  assign rd1 = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rd2 = (rt == 5'd0) ? 32'd0 : rf[rt];

  assign WriteDataMem = rd2;
  assign srcb = ALUSrc ? (zero_ext ? imm_zext : imm_sext) : rd2;

  // ALU
  always_comb begin
    ALUresult = 32'd0;
    case (ALUControl)
      ALU_AND: ALUresult = rd1 & srcb;
      ALU_OR:  ALUresult = rd1 | srcb;
      ALU_ADD: ALUresult = rd1 + srcb;
      ALU_SUB: ALUresult = rd1 - srcb;
      ALU_SLT: ALUresult = {31'd0, ($signed(rd1) < $signed(srcb))};
      ALU_NOR: ALUresult = ~(rd1 | srcb);
      default: ALUresult = rd1 + srcb;
    endcase
  end

  assign zero = (ALUresult == 32'd0);

  // Data RAM: combinational read, word addressed by ALUresult
  assign dmem_idx_full = ALUresult[31:2] % 30'(DMEM_DEPTH);
  assign ReadDataMem   = dmem[dmem_idx_full[DAW-1:0]];

  assign unused_idx = ^{imem_idx_full, dmem_idx_full, ALUresult[1:0]};

  // Write-back selection
  assign pc_plus4 = pc + 32'd4;
  assign wa3 = JAL ? 5'd31 : (RegDst ? rd : rt);
  assign WD3 = JAL ? pc_plus4 : (MemtoReg ? ReadDataMem : ALUresult);

  // Next-pc selection, JR has the highest priority
  assign pcjump       = {pc_plus4[31:28], inst[25:0], 2'b00};
  assign pc_branch    = pc_plus4 + {imm_sext[29:0], 2'b00};
  assign branch_taken = (BEQ & zero) | (BNE & ~zero);
  assign pc_next      = JR ? rd1 : (jump ? pcjump : (branch_taken ? pc_branch : pc_plus4));

  // Program counter, cleared asynchronously
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) pc <= 32'd0;
    else       pc <= pc_next;
  end

  // Register file write port; reset clears every register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (RegWrite && (wa3 != 5'd0)) begin
      rf[wa3] <= WD3;
    end
  end

  // Data RAM write port; contents survive reset
  always_ff @(posedge CLK) begin
    if (!reset && MemWrite) dmem[dmem_idx_full[DAW-1:0]] <= WriteDataMem;
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_single_cycle_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_single_cycle_top
// Description : Directed self-checking bench for mips_single_cycle_top.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_single_cycle_top;

  logic        CLK;
  logic        reset;
  logic [31:0] pc, inst, ALUresult, WriteDataMem, ReadDataMem, WD3, pcjump;
  logic [3:0]  ALUControl;
  logic        MemWrite, RegWrite, RegDst, ALUSrc, MemtoReg;
  logic        BEQ, BNE, jump, JR, JAL, zero;

  int n_assert = 0;
  int n_fail   = 0;

  mips_single_cycle_top #(
    .IMEM_DEPTH(64),
    .DMEM_DEPTH(64),
    .IMEM_FILE ("")
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .pc          (pc),
    .inst        (inst),
    .ALUresult   (ALUresult),
    .WriteDataMem(WriteDataMem),
    .ReadDataMem (ReadDataMem),
    .WD3         (WD3),
    .pcjump      (pcjump),
    .ALUControl  (ALUControl),
    .MemWrite    (MemWrite),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .ALUSrc      (ALUSrc),
    .MemtoReg    (MemtoReg),
    .BEQ         (BEQ),
    .BNE         (BNE),
    .jump        (jump),
    .JR          (JR),
    .JAL         (JAL),
    .zero        (zero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 64; i++) dut.imem[i] = 32'h0000_0000;
    dut.imem[0]  = 32'h2001_0005; // 00 addi $1,$0,5
    dut.imem[1]  = 32'h2002_FFFD; // 04 addi $2,$0,-3
    dut.imem[2]  = 32'h0022_1820; // 08 add  $3,$1,$2
    dut.imem[3]  = 32'hAC03_0008; // 0C sw   $3,8($0)
    dut.imem[4]  = 32'h8C04_0008; // 10 lw   $4,8($0)
    dut.imem[5]  = 32'h1421_0002; // 14 bne  $1,$1,+2
    dut.imem[6]  = 32'h1021_0002; // 18 beq  $1,$1,+2
    dut.imem[7]  = 32'h2006_0063; // 1C skipped
    dut.imem[8]  = 32'h2006_0063; // 20 skipped
    dut.imem[9]  = 32'h0041_282A; // 24 slt  $5,$2,$1
    dut.imem[10] = 32'hFC00_0000; // 28 undefined opcode
    dut.imem[11] = 32'h0023_3025; // 2C or   $6,$1,$3
    dut.imem[12] = 32'h0C00_0010; // 30 jal  0x10
    dut.imem[13] = 32'h0022_3822; // 34 sub  $7,$1,$2
    dut.imem[14] = 32'h0800_000E; // 38 j    0x38
    dut.imem[16] = 32'h03E0_0008; // 40 jr   $31

    // Reset held for 22 ns: pc pinned at 0, no register update
    #10;
    chk("reset_pc_10ns", pc, 32'h0);
    #10;
    chk("reset_pc_20ns", pc, 32'h0);
    chk("reset_r1", dut.rf[1], 32'h0);
    #2;
    reset = 1'b0;
    #1;

    // addi $1,$0,5
    chk("addi1_pc", pc, 32'h00);
    chk("addi1_inst", inst, 32'h2001_0005);
    chk("addi1_wd3", WD3, 32'd5);
    chk("addi1_regwrite", {31'd0, RegWrite}, 32'd1);
    chk("addi1_aluctl", {28'd0, ALUControl}, 32'h2);
    step();
    // addi $2,$0,-3
    chk("addi2_pc", pc, 32'h04);
    chk("addi2_wd3", WD3, 32'hFFFF_FFFD);
    step();
    // add $3,$1,$2
    chk("add_pc", pc, 32'h08);
    chk("add_wd3", WD3, 32'd2);
    chk("add_aluctl", {28'd0, ALUControl}, 32'h2);
    step();
    // sw $3,8($0)
    chk("sw_pc", pc, 32'h0C);
    chk("sw_memwrite", {31'd0, MemWrite}, 32'd1);
    chk("sw_regwrite", {31'd0, RegWrite}, 32'd0);
    chk("sw_aluresult", ALUresult, 32'd8);
    chk("sw_wdata", WriteDataMem, 32'd2);
    step();
    // lw $4,8($0)
    chk("lw_pc", pc, 32'h10);
    chk("lw_rdata", ReadDataMem, 32'd2);
    chk("lw_wd3", WD3, 32'd2);
    chk("lw_memtoreg", {31'd0, MemtoReg}, 32'd1);
    step();
    // bne $1,$1,+2 (not taken)
    chk("bne_pc", pc, 32'h14);
    chk("bne_flag", {31'd0, BNE}, 32'd1);
    chk("bne_zero", {31'd0, zero}, 32'd1);
    step();
    // beq $1,$1,+2 (taken to 0x24)
    chk("beq_pc", pc, 32'h18);
    chk("beq_flag", {31'd0, BEQ}, 32'd1);
    chk("beq_zero", {31'd0, zero}, 32'd1);
    step();
    // slt $5,$2,$1
    chk("slt_pc", pc, 32'h24);
    chk("slt_wd3", WD3, 32'd1);
    chk("slt_aluctl", {28'd0, ALUControl}, 32'h7);
    step();
    // undefined opcode
    chk("undef_pc", pc, 32'h28);
    chk("undef_ctrl", {22'd0, MemWrite, RegWrite, RegDst, ALUSrc, MemtoReg,
                       BEQ, BNE, jump, JR, JAL}, 32'd0);
    chk("undef_aluctl", {28'd0, ALUControl}, 32'h2);
    step();
    // or $6,$1,$3
    chk("or_pc", pc, 32'h2C);
    chk("or_wd3", WD3, 32'd7);
    chk("or_aluctl", {28'd0, ALUControl}, 32'h1);
    step();
    // jal 0x10
    chk("jal_pc", pc, 32'h30);
    chk("jal_pcjump", pcjump, 32'h40);
    chk("jal_wd3", WD3, 32'h34);
    chk("jal_flags", {29'd0, jump, JAL, RegWrite}, 32'h7);
    step();
    // jr $31
    chk("jr_pc", pc, 32'h40);
    chk("jr_flag", {31'd0, JR}, 32'd1);
    chk("jr_regwrite", {31'd0, RegWrite}, 32'd0);
    step();
    // sub $7,$1,$2
    chk("sub_pc", pc, 32'h34);
    chk("sub_wd3", WD3, 32'd8);
    chk("sub_aluctl", {28'd0, ALUControl}, 32'h6);
    step();
    // j 0x38 (self loop)
    chk("j_pc", pc, 32'h38);
    chk("j_flag", {31'd0, jump}, 32'd1);
    chk("j_pcjump", pcjump, 32'h38);
    step();
    chk("j_loop_pc", pc, 32'h38);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
